// File: rtl/fft4_frame_loader_if.sv
// Sample-stream and frame-output signals of the FFT4 frame loader.
// Optional s_last is present only when LOADER_TLAST_EN is defined.
interface fft4_frame_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
`ifdef LOADER_TLAST_EN
  logic        s_last;
`endif
  logic [31:0] m_vin0;
  logic [31:0] m_vin1;
  logic [31:0] m_vin2;
  logic [31:0] m_vin3;
  logic        m_valid;
  logic        m_ready;

  // slave: the loader itself; master: the surrounding producer/consumer environment
  modport slave (
    input  s_data, s_valid, m_ready,
`ifdef LOADER_TLAST_EN
    input  s_last,
`endif
    output s_ready, m_vin0, m_vin1, m_vin2, m_vin3, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
`ifdef LOADER_TLAST_EN
    output s_last,
`endif
    input  s_ready, m_vin0, m_vin1, m_vin2, m_vin3, m_valid
  );
endinterface

// File: rtl/fft4_frame_loader.sv
// Collects packed complex samples into 4-sample frames for the FFT4 stage and emits a
// latency-matched output strobe. Optional macro LOADER_TLAST_EN adds s_last/frame_err.
module fft4_frame_loader #(
  parameter int unsigned FFT_LATENCY = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fft4_frame_loader_if.slave   bus,
  output logic                 fft_valid,
  output logic [CNT_W-1:0]     frame_cnt
`ifdef LOADER_TLAST_EN
  ,
  output logic                 frame_err
`endif
);

  logic [31:0]            slot_q [4];
  logic [31:0]            slot_d [4];
  logic [31:0]            vin_q  [4];
  logic [31:0]            vin_d  [4];
  logic [1:0]             ptr_q, ptr_d;
  logic                   buf_full_q, buf_full_d;
  logic                   m_valid_q, m_valid_d;
  logic [FFT_LATENCY-1:0] dly_q, dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   xfer, s_acc, fire;
`ifdef LOADER_TLAST_EN
  logic                   err_q, err_d;
`endif

  // s_ready looks through to m_ready so a frame can leave and a new one start in one cycle
  assign xfer        = buf_full_q & (~m_valid_q | bus.m_ready);
  assign bus.s_ready = ~buf_full_q | xfer;
  assign s_acc       = bus.s_valid & bus.s_ready;
  assign fire        = m_valid_q & bus.m_ready;

  always_comb begin
    slot_d     = slot_q;
    ptr_d      = ptr_q;
    buf_full_d = buf_full_q & ~xfer;
`ifdef LOADER_TLAST_EN
    err_d      = err_q;
`endif
    if (s_acc) begin
      slot_d[ptr_q] = bus.s_data;
      ptr_d         = ptr_q + 2'd1;
      if (ptr_q == 2'd3) begin
        buf_full_d = 1'b1;
      end
`ifdef LOADER_TLAST_EN
      else if (bus.s_last) begin
        // Short burst: pad the rest of the frame with zeros and close it early
        for (int i = 0; i < 4; i++) begin
          if (i > int'(ptr_q)) slot_d[i] = '0;
        end
        ptr_d      = 2'd0;
        buf_full_d = 1'b1;
        err_d      = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    vin_d     = vin_q;
    m_valid_d = m_valid_q;
    cnt_d     = cnt_q;
    if (xfer) begin
      vin_d     = slot_q;
      m_valid_d = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
    if (fire) cnt_d = cnt_q + CNT_W'(1);
    dly_d[0] = fire;
    for (int i = 1; i < int'(FFT_LATENCY); i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '{default: '0};
      vin_q      <= '{default: '0};
      ptr_q      <= 2'd0;
      buf_full_q <= 1'b0;
      m_valid_q  <= 1'b0;
      dly_q      <= '0;
      cnt_q      <= '0;
    end else begin
      slot_q     <= slot_d;
      vin_q      <= vin_d;
      ptr_q      <= ptr_d;
      buf_full_q <= buf_full_d;
      m_valid_q  <= m_valid_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef LOADER_TLAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign frame_err = err_q;
`endif

  assign bus.m_vin0  = vin_q[0];
  assign bus.m_vin1  = vin_q[1];
  assign bus.m_vin2  = vin_q[2];
  assign bus.m_vin3  = vin_q[3];
  assign bus.m_valid = m_valid_q;
  assign fft_valid   = dly_q[FFT_LATENCY-1];
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Directed bench for fft4_frame_loader (FFT_LATENCY=5, CNT_W=2 so the frame counter wraps).
`timescale 1ns/1ps
module tb_fft4_frame_loader;
  logic         clk = 1'b0;
  logic         rst;
  logic         fft_valid;
  logic [1:0]   frame_cnt;
`ifdef LOADER_TLAST_EN
  logic         frame_err;
`endif
  logic [127:0] frame;
  int           errors = 0;
  int           checks = 0;

  fft4_frame_loader_if bus ();

  fft4_frame_loader #(
    .FFT_LATENCY(5),
    .CNT_W      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .fft_valid(fft_valid),
    .frame_cnt(frame_cnt)
`ifdef LOADER_TLAST_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  assign frame = {bus.m_vin0, bus.m_vin1, bus.m_vin2, bus.m_vin3};

  // Stimulus changes at posedge+1, observation happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b want=0", bus.m_valid); end
    checks++; if (fft_valid !== 1'b0) begin errors++; $display("FAIL reset_fft_valid got=%0b want=0", fft_valid); end
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%0b want=1", bus.s_ready); end
    checks++; if (frame !== 128'd0) begin errors++; $display("FAIL reset_m_vin got=%h want=0", frame); end
    tick();
    rst = 1'b0;
  endtask

  // Continuous stream, consumer always ready: frames at cycles 6 and 10, strobes at 11 and 15.
  task automatic test_stream();
    logic       exp_mv;
    logic [1:0] exp_cnt;
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus.s_valid = (k <= 8);
      bus.s_data  = {16'(k), 16'(k)};
      @(negedge clk);
      if (k <= 8) begin
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready c%0d got=%0b want=1", k, bus.s_ready); end
      end
      exp_mv = (k == 6) || (k == 10);
      checks++; if (bus.m_valid !== exp_mv) begin errors++; $display("FAIL stream_m_valid c%0d got=%0b want=%0b", k, bus.m_valid, exp_mv); end
      if (k == 6) begin
        checks++; if (frame !== 128'h00010001_00020002_00030003_00040004) begin errors++; $display("FAIL stream_frame1 got=%h want=00010001000200020003000300040004", frame); end
      end
      if (k == 10) begin
        checks++; if (frame !== 128'h00050005_00060006_00070007_00080008) begin errors++; $display("FAIL stream_frame2 got=%h want=00050005000600060007000700080008", frame); end
      end
      checks++; if (fft_valid !== ((k == 11) || (k == 15))) begin errors++; $display("FAIL stream_fft_valid c%0d got=%0b want=%0b", k, fft_valid, (k == 11) || (k == 15)); end
      exp_cnt = (k > 10) ? 2'd2 : (k > 6) ? 2'd1 : 2'd0;
      checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL stream_frame_cnt c%0d got=%0d want=%0d", k, frame_cnt, exp_cnt); end
      tick();
    end
  endtask

  // Two frames pile up under backpressure, then leave back to back.
  task automatic test_back_to_back();
    logic [31:0] d [8];
    int          idx;
    logic        exp_mv;
    for (int i = 0; i < 8; i++) d[i] = {16'h1100 + 16'(i), 16'h2200 + 16'(i)};
    idx = 0;
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.s_valid = (idx < 8);
      bus.s_data  = d[idx % 8];
      @(negedge clk);
      if (k >= 6) begin
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid c%0d got=%0b want=1", k, bus.m_valid); end
        checks++; if (frame !== {d[0], d[1], d[2], d[3]}) begin errors++; $display("FAIL bp_held_frame c%0d got=%h want=%h", k, frame, {d[0], d[1], d[2], d[3]}); end
      end
      if (k == 12) begin
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got=%0b want=0", bus.s_ready); end
      end
      if (bus.s_valid && bus.s_ready) idx++;
      tick();
    end
    checks++; if (idx !== 8) begin errors++; $display("FAIL bp_accepted got=%0d want=8", idx); end
    checks++; if (frame_cnt !== 2'd2) begin errors++; $display("FAIL bp_frame_cnt got=%0d want=2", frame_cnt); end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      exp_mv = (k <= 1);
      checks++; if (bus.m_valid !== exp_mv) begin errors++; $display("FAIL b2b_m_valid r%0d got=%0b want=%0b", k, bus.m_valid, exp_mv); end
      if (k == 0) begin
        checks++; if (frame !== {d[0], d[1], d[2], d[3]}) begin errors++; $display("FAIL b2b_frame1 got=%h want=%h", frame, {d[0], d[1], d[2], d[3]}); end
      end
      if (k == 1) begin
        checks++; if (frame !== {d[4], d[5], d[6], d[7]}) begin errors++; $display("FAIL b2b_frame2 got=%h want=%h", frame, {d[4], d[5], d[6], d[7]}); end
        checks++; if (frame_cnt !== 2'd3) begin errors++; $display("FAIL b2b_frame_cnt3 got=%0d want=3", frame_cnt); end
      end
      if (k == 2) begin
        checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL b2b_frame_cnt_wrap got=%0d want=0", frame_cnt); end
      end
      checks++; if (fft_valid !== ((k == 5) || (k == 6))) begin errors++; $display("FAIL b2b_fft_valid r%0d got=%0b want=%0b", k, fft_valid, (k == 5) || (k == 6)); end
      tick();
    end
  endtask

  // Reset with a frame held and a partial frame in the slots, then a clean frame.
  task automatic test_reset_midframe();
    logic [31:0] e [10];
    logic [31:0] f [4];
    int          idx;
    int          seen;
    logic [127:0] got;
    for (int i = 0; i < 10; i++) e[i] = {16'h0A0A, 16'(i + 1)};
    for (int i = 0; i < 4; i++) f[i] = {16'h5B5B, 16'(i + 16'h40)};
    idx = 0;
    for (int k = 1; k <= 10; k++) begin
      bus.m_ready = (k <= 6);
      bus.s_valid = (idx < 10);
      bus.s_data  = e[idx % 10];
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
      tick();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++; if (idx !== 10) begin errors++; $display("FAIL rst_pre_accepted got=%0d want=10", idx); end
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_m_valid got=%0b want=1", bus.m_valid); end
    checks++; if (frame !== {e[4], e[5], e[6], e[7]}) begin errors++; $display("FAIL rst_pre_frame got=%h want=%h", frame, {e[4], e[5], e[6], e[7]}); end
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL rst_pre_frame_cnt got=%0d want=1", frame_cnt); end
    checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_fft_valid got=%0b want=1", fft_valid); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid got=%0b want=0", bus.m_valid); end
      checks++; if (fft_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_fft_valid got=%0b want=0", fft_valid); end
      checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL rst_mid_frame_cnt got=%0d want=0", frame_cnt); end
      checks++; if (frame !== 128'd0) begin errors++; $display("FAIL rst_mid_m_vin got=%h want=0", frame); end
      tick();
    end
    rst = 1'b0;
    bus.m_ready = 1'b1;
    seen = 0;
    got  = '0;
    for (int k = 1; k <= 10; k++) begin
      bus.s_valid = (k <= 4);
      bus.s_data  = f[(k - 1) % 4];
      @(negedge clk);
      if (bus.m_valid) begin
        seen++;
        got = frame;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_post_frames got=%0d want=1", seen); end
    checks++; if (got !== {f[0], f[1], f[2], f[3]}) begin errors++; $display("FAIL rst_post_frame got=%h want=%h", got, {f[0], f[1], f[2], f[3]}); end
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL rst_post_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

`ifdef LOADER_TLAST_EN
  // Short burst closed by s_last on slot 1; slots 2..3 still hold old data and must be zeroed.
  task automatic test_tlast();
    logic [31:0] g [2];
    logic [31:0] h [4];
    int          seen;
    logic [127:0] got;
    g[0] = 32'hAAAA5555;
    g[1] = 32'h12343456;
    for (int i = 0; i < 4; i++) h[i] = {16'h7700, 16'(i + 1)};
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tlast_err_initial got=%0b want=0", frame_err); end
    tick();
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.s_valid = (k <= 2);
      bus.s_data  = g[(k - 1) % 2];
      bus.s_last  = (k == 2);
      @(negedge clk);
      if (k == 4) begin
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL tlast_m_valid got=%0b want=1", bus.m_valid); end
        checks++; if (frame !== {g[0], g[1], 64'd0}) begin errors++; $display("FAIL tlast_frame got=%h want=%h", frame, {g[0], g[1], 64'd0}); end
      end
      tick();
    end
    bus.s_last = 1'b0;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL tlast_err_set got=%0b want=1", frame_err); end
    seen = 0;
    got  = '0;
    for (int k = 1; k <= 8; k++) begin
      bus.s_valid = (k <= 4);
      bus.s_data  = h[(k - 1) % 4];
      @(negedge clk);
      if (bus.m_valid) begin
        seen++;
        got = frame;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    checks++; if (got !== {h[0], h[1], h[2], h[3]} || seen !== 1) begin errors++; $display("FAIL tlast_next_frame got=%h n=%0d want=%h n=1", got, seen, {h[0], h[1], h[2], h[3]}); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL tlast_err_sticky got=%0b want=1", frame_err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tlast_err_reset got=%0b want=0", frame_err); end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
`ifdef LOADER_TLAST_EN
    bus.s_last  = 1'b0;
`endif
    test_reset();
    test_stream();
    test_back_to_back();
    test_reset_midframe();
`ifdef LOADER_TLAST_EN
    test_tlast();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft4_frame_loader.md
Name: fft4_frame_loader

Overview:
Upstream feeder for the 4-point FFT stage. It collects a stream of packed complex samples ({imag[31:16], real[15:0]}, signed Q1.15) into 4-sample frames. Each complete frame is presented in parallel on four 32-bit words, held stable under a valid/ready handshake, and wired directly to the FFT4 Vin0..Vin3 inputs. The block also produces a latency-matched strobe that marks the cycle when the FFT4 outputs for an accepted frame are valid.

Parameters:
FFT_LATENCY, 5, cycles from frame acceptance (m_valid & m_ready) to the cycle in which the FFT4 outputs are valid; legal range 1..16.
CNT_W, 16, width of the accepted-frame counter.

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
s_data  input  32  sample in: [31:16] imaginary, [15:0] real
s_valid  input  1  s_data valid
s_ready  output  1  loader can accept s_data this cycle
m_vin0  output  32  frame sample 0 (first received); drives FFT4 Vin0
m_vin1  output  32  frame sample 1; drives FFT4 Vin1
m_vin2  output  32  frame sample 2; drives FFT4 Vin2
m_vin3  output  32  frame sample 3 (last received); drives FFT4 Vin3
m_valid  output  1  m_vin0..3 hold a complete frame
m_ready  input  1  consumer takes the frame this cycle
fft_valid  output  1  one-cycle strobe, FFT_LATENCY cycles after each frame acceptance
frame_cnt  output  CNT_W  number of frames accepted on the m_ interface, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release):
  - s_ready=1 once the reset condition clears; m_valid=0; fft_valid=0; frame_cnt=0.
  - m_vin0..3 are cleared to 0; slot pointer=0; buf_full=0; delay line cleared.
  - A partial frame is discarded. A held, unaccepted frame is discarded.
- Collection buffer: four 32-bit slots plus a 2-bit slot pointer.
  - Sample accept = s_valid & s_ready. The sample is written to slot[ptr], then ptr increments (wraps 3->0).
  - Accepting into slot 3 sets buf_full on the next edge.
- Transfer: xfer = buf_full & (!m_valid | m_ready).
  - On xfer, slots 0..3 are copied to m_vin0..3, m_valid is set and buf_full is cleared.
  - If m_ready=1 and no xfer occurs, m_valid is cleared.
- s_ready = !buf_full | xfer. This is a combinational path from m_ready, which gives 100% throughput.
  - When xfer occurs, a new sample may be accepted into slot 0 in the same cycle.
- Latency with m_ready held high: slot-3 sample accepted at cycle N -> buf_full=1 at N+1 -> m_valid=1 at N+2 (m_vin registered).
- Backpressure: m_ready=0 with m_valid=1.
  - The held frame stays stable.
  - A second full frame waits in the slots with s_ready=0 until the held frame is taken.
- The handshake follows AXI-stream rules. m_vin must not change while m_valid=1 & m_ready=0. s_valid may assert while s_ready=0; the sample is simply not taken.
- fft_valid: a shift register of FFT_LATENCY stages, fed by (m_valid & m_ready).
  - Back-to-back frames give back-to-back strobes.
  - The strobe is not suppressed by later backpressure.
- frame_cnt increments on every m_valid & m_ready. It wraps from all-ones to 0.
- No arithmetic is done on sample data. Bits pass through unchanged; no sign handling.

Optional Feature:
Macro LOADER_TLAST_EN.
- Defined: adds two ports.
  - s_last (input 1): marks the final sample of a burst.
  - frame_err (output 1): sticky error flag, reset 0.
- If s_last is accepted into slot k with k<3:
  - slots k+1..3 are zero-filled;
  - buf_full is set on the next edge, exactly as for a slot-3 accept;
  - ptr returns to 0;
  - frame_err sets and stays 1 until rst.
- s_last on slot 3 is a normal frame end and does not set frame_err.
- Undefined: neither port exists, and frames are always exactly 4 accepted samples.

Test Plan:
- Reset then stream samples 0x00010001..0x00080008 continuously, m_ready=1 -> frame 1 on m_valid at N+2 after the 4th sample, m_vin0..3=0x00010001..0x00040004; frame 2 = 0x00050005..0x00080008; s_ready stays 1 throughout; frame_cnt=2.
- FFT_LATENCY=5: frame accepted at cycle T -> fft_valid=1 exactly at T+5, for one cycle; two consecutive acceptances -> strobes at T+5 and T+6.
- m_ready=0 while 8 samples are offered -> first frame held stable; s_ready drops after the 8th accept; release m_ready -> frame 1 then frame 2 delivered, no loss, no duplication.
- Assert rst after 2 samples of a frame, then send 4 new samples -> output frame contains only the 4 new samples; m_valid, fft_valid and frame_cnt are 0 during reset.
- frame_cnt wrap: CNT_W=2, 5 frames accepted -> frame_cnt sequence 1,2,3,0,1.
- LOADER_TLAST_EN: s_last on the 2nd sample (0xAAAA5555, 0x12343456) -> m_vin0=0xAAAA5555, m_vin1=0x12343456, m_vin2=m_vin3=0; frame_err=1 until rst.
